// File: rtl/onchip_dpram_ctrl_if.sv
// Avalon-MM pipelined slave port bundle for one side of onchip_dpram_ctrl.
interface onchip_dpram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );
    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_dpram_ctrl.sv
// Dual-port on-chip RAM with two Avalon-MM pipelined slaves, write-first forwarding
// and same-address write arbitration. Define ONCHIP_DPRAM_INIT_CLEAR_EN to zero the array after reset.
module onchip_dpram_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_dpram_ctrl_if.slave   port_a,
    onchip_dpram_ctrl_if.slave   port_b,
    output logic                 init_done
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t state, state_nxt;
    logic   run;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][BE_W-1:0]   be;
    logic [1:0][DATA_W-1:0] wdata, rdata;
    logic [1:0]             cs, rd, wr, wait_req, rvld, req, wr_acc, rd_acc;
    logic                   coll;

    assign addr  = {port_b.address,    port_a.address};
    assign be    = {port_b.byteenable, port_a.byteenable};
    assign wdata = {port_b.writedata,  port_a.writedata};
    assign cs    = {port_b.chipselect, port_a.chipselect};
    assign rd    = {port_b.read,       port_a.read};
    assign wr    = {port_b.write,      port_a.write};

    assign run       = (state == ST_RUN);
    assign init_done = run;

    // Same-address double write: a wins, b retries next cycle.
    assign coll        = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
    assign wait_req[0] = ~run;
    assign wait_req[1] = ~run | coll;

    assign req    = cs & (rd | wr);
    assign wr_acc = req & wr & ~wait_req;
    assign rd_acc = req & rd & ~wr & ~wait_req;

`ifdef ONCHIP_DPRAM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            clr_cnt <= '0;
        else if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef ONCHIP_DPRAM_INIT_CLEAR_EN
            ST_INIT: if (&clr_cnt) state_nxt = ST_RUN;
`else
            ST_INIT: state_nxt = ST_RUN;
`endif
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Array has no reset; only the clear sequence touches it outside normal writes.
    always_ff @(posedge clk) begin
`ifdef ONCHIP_DPRAM_INIT_CLEAR_EN
        if (reset_n && state == ST_INIT) mem[clr_cnt] <= '0;
`endif
        for (int p = 0; p < 2; p++)
            if (wr_acc[p])
                for (int i = 0; i < BE_W; i++)
                    if (be[p][i]) mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int Q = 1 - p;
        logic [DATA_W-1:0]                 rd_merged;
        logic [READ_LATENCY:1]             vld_pipe;
        logic [READ_LATENCY:1][DATA_W-1:0] dat_pipe;

        // Write-first: bytes the other port is writing this cycle override the array.
        always_comb begin
            rd_merged = mem[addr[p]];
            for (int i = 0; i < BE_W; i++)
                if (wr_acc[Q] && addr[Q] == addr[p] && be[Q][i])
                    rd_merged[8*i +: 8] = wdata[Q][8*i +: 8];
        end

        // Data stages only load with their valid, so readdata holds between pulses.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_pipe <= '0;
                dat_pipe <= '0;
            end else begin
                vld_pipe[1] <= rd_acc[p];
                if (rd_acc[p]) dat_pipe[1] <= rd_merged;
                for (int k = 2; k <= READ_LATENCY; k++) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
                end
            end
        end

        assign rdata[p] = dat_pipe[READ_LATENCY];
        assign rvld[p]  = vld_pipe[READ_LATENCY];
    end

    assign port_a.readdata      = rdata[0];
    assign port_a.readdatavalid = rvld[0];
    assign port_a.waitrequest   = wait_req[0];
    assign port_b.readdata      = rdata[1];
    assign port_b.readdatavalid = rvld[1];
    assign port_b.waitrequest   = wait_req[1];
endmodule
